param_regfile: RTL
==================

// Module: param_regfile
// PURPOSE
//   Parametrised multi-entry register file for the CPU datapath; generalises
//   the single N-bit register to DEPTH words of WIDTH bits.
//   Provides one synchronous write port, two combinational read ports with
//   same-cycle write bypass, an optional hardwired-zero entry 0, and a
//   per-entry busy scoreboard (set at issue, cleared at writeback).
//   Sits between decode (reads, busy_set) and writeback (we/waddr/wdata).
// PARAMETERS
//   WIDTH     32  data bits per entry
//   DEPTH     16  number of entries; power of two, >= 2
//   AW        4   address width, must equal log2(DEPTH)
//   ZERO_REG  1   1: entry 0 always reads 0, ignores writes and busy_set
// PORTS
//   clk       in   1      rising-edge clock, sole clock domain
//   rst       in   1      synchronous reset, active-high
//   we        in   1      write enable (writeback)
//   waddr     in   AW     write address
//   wdata     in   WIDTH  write data
//   raddr_a   in   AW     read port A address
//   rdata_a   out  WIDTH  read port A data (combinational)
//   raddr_b   in   AW     read port B address
//   rdata_b   out  WIDTH  read port B data (combinational)
//   busy_set  in   1      mark entry busy_addr as pending a write
//   busy_addr in   AW     scoreboard set address
//   busy_a    out  1      entry raddr_a pending (combinational)
//   busy_b    out  1      entry raddr_b pending (combinational)
// BEHAVIOUR
//   - Clock: one clock, clk; reset is synchronous and active-high, rst.
//   - Reset: at a clk edge with rst=1, all DEPTH entries <= 0 and all busy
//     bits <= 0. we and busy_set are ignored on that edge.
//   - After reset, rdata_a/b = 0 and busy_a/b = 0 for every address.
//   - Write: at a clk edge with rst=0 and we=1, mem[waddr] <= wdata and
//     busy[waddr] <= 0. Write latency is 1 edge.
//   - Read: rdata_x = mem[raddr_x] combinationally, with 0 cycles latency.
//   - Bypass: if we=1 and waddr==raddr_x, rdata_x = wdata in the same cycle
//     (write-before-read). Both ports may bypass simultaneously.
//   - Zero entry (ZERO_REG=1): rdata_x = 0 whenever raddr_x==0, including
//     during bypass. Writes to 0 are dropped, busy[0] is never set, and
//     busy_x = 0 for address 0.
//   - Scoreboard: at an edge with rst=0 and busy_set=1, busy[busy_addr] <= 1.
//   - Simultaneous writeback clear and busy_set to the same entry: set wins,
//     busy stays 1 (a new producer was issued).
//   - busy_x = busy[raddr_x] & ~(we & waddr==raddr_x). A same-cycle
//     writeback is forwarded, so the entry reads not busy.
//   - Write to a non-busy entry is legal; data updates and busy stays 0.
//   - Address out of range cannot occur (DEPTH = 2**AW).
//   - No internal state besides mem and busy; no FSM. Outputs are fully
//     determined by state plus current inputs.
// TESTING
//   1 Reset: preload entries, assert rst 1 cycle with we=1 -> every read 0,
//     busy 0; write suppressed.
//   2 Write/read: we=1 waddr=5 wdata=32'hDEADBEEF, next cycle raddr_a=5
//     -> rdata_a=32'hDEADBEEF; raddr_b=6 -> 0.
//   3 Bypass: mem[3]=32'h11, same cycle we=1 waddr=3 wdata=32'h22 raddr_a=
//     raddr_b=3 -> rdata_a=rdata_b=32'h22; next cycle both still 32'h22.
//   4 Zero reg: we=1 waddr=0 wdata=32'hFFFF_FFFF, busy_set addr 0 -> rdata
//     at 0 is 0 same and next cycle, busy_a=0.
//   5 Scoreboard: busy_set addr 7 -> busy_a(7)=1 next cycle; we waddr=7
//     -> busy_a=0 that cycle, stays 0 after edge.
//   6 Collision: busy[9]=1, same edge we waddr=9 + busy_set addr 9 -> busy
//     remains 1, mem[9] updated; random regression vs. reference model.

Source files
------------

// File: rtl/param_regfile.sv
// rtl/param_regfile.sv - DEPTH x WIDTH register file, 1 write / 2 bypassed read ports, busy scoreboard
module param_regfile #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  output logic             busy_a,
  output logic             busy_b
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_ok;
  logic set_ok;
  assign wr_ok  = we && !(HAS_ZERO && waddr == '0);
  assign set_ok = busy_set && !(HAS_ZERO && busy_addr == '0);

  // The set is applied after the clear so a same-edge new issue keeps the entry busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[waddr]  <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (set_ok) begin
        busy[busy_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata_a = mem[raddr_a];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (HAS_ZERO && raddr_a == '0) rdata_a = '0;
  end

  always_comb begin
    rdata_b = mem[raddr_b];
    if (we && waddr == raddr_b) rdata_b = wdata;
    if (HAS_ZERO && raddr_b == '0) rdata_b = '0;
  end

  // A same-cycle writeback is forwarded, so the entry is no longer pending.
  assign busy_a = busy[raddr_a] && !(we && waddr == raddr_a);
  assign busy_b = busy[raddr_b] && !(we && waddr == raddr_b);

endmodule
